// File: rtl/cwalk_pkg.sv
// Shared types and default timing constants for the crosswalk controller.
// Timer width is derived from the longest default duration.
package cwalk_pkg;

   typedef enum logic [1:0] {
      ST_STOP  = 2'd0,
      ST_WALK  = 2'd1,
      ST_FLASH = 2'd2
   } state_t;

   localparam int DEF_HAND_CYC  = 20;
   localparam int DEF_WALK_CYC  = 16;
   localparam int DEF_CNT_START = 9;
   localparam int DEF_CNT_CYC   = 2;

   function automatic int tmr_width(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      m = (m > c) ? m : c;
      return $clog2(m + 1);
   endfunction

   localparam int TMR_W = tmr_width(DEF_HAND_CYC, DEF_WALK_CYC, DEF_CNT_CYC);

endpackage

// File: rtl/cwalk_timer.sv
// Loadable saturating down-counter; o_tc is high while the count is zero.
// Load takes effect on the next edge; no backpressure, free-running.
module cwalk_timer
   import cwalk_pkg::*;
#(
   parameter int           W       = TMR_W,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_load,
   input  logic [W-1:0] i_val,
   output logic [W-1:0] o_cnt,
   output logic         o_tc
);

   logic [W-1:0] r_cnt;
   logic [W-1:0] w_cnt_nxt;

   always_comb begin
      w_cnt_nxt = r_cnt;
      if (i_load)
         w_cnt_nxt = i_val;
      else if (r_cnt != '0)
         w_cnt_nxt = r_cnt - W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_cnt <= RST_VAL;
      else
         r_cnt <= w_cnt_nxt;
   end

   assign o_cnt = r_cnt;
   assign o_tc  = (r_cnt == '0);

endmodule

// File: rtl/cwalk.sv
// Free-running pedestrian signal: STOP -> WALK -> FLASH countdown -> STOP.
// All outputs registered and change on the same edge as the state; no backpressure.
module cwalk
   import cwalk_pkg::*;
#(
   parameter int HAND_CYC  = DEF_HAND_CYC,
   parameter int WALK_CYC  = DEF_WALK_CYC,
   parameter int CNT_START = DEF_CNT_START,
   parameter int CNT_CYC   = DEF_CNT_CYC
) (
   input  logic       clk,
   input  logic       reset,
   output logic       walk,
   output logic       hand,
   output logic       num_on,
   output logic [3:0] num
);

   localparam int            TW      = tmr_width(HAND_CYC, WALK_CYC, CNT_CYC);
   localparam logic [TW-1:0] HAND_TH = TW'(CNT_CYC - CNT_CYC / 2);

   state_t        r_state, w_state_nxt;
   logic [3:0]    r_dig, w_dig_nxt;
   logic          w_load;
   logic [TW-1:0] w_load_val;
   logic [TW-1:0] w_cnt;
   logic          w_tc;
   logic          w_walk_nxt, w_hand_nxt, w_num_on_nxt;
   logic [3:0]    w_num_nxt;
   logic          r_walk, r_hand, r_num_on;
   logic [3:0]    r_num;

   // One timer serves both the STOP/WALK duration and each FLASH digit step.
   cwalk_timer #(
      .W       (TW),
      .RST_VAL (TW'(HAND_CYC - 1))
   ) u_tmr (
      .clk    (clk),
      .reset  (reset),
      .i_load (w_load),
      .i_val  (w_load_val),
      .o_cnt  (w_cnt),
      .o_tc   (w_tc)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_dig_nxt   = r_dig;
      w_load      = 1'b0;
      w_load_val  = '0;
      case (r_state)
         ST_STOP: begin
            if (w_tc) begin
               w_state_nxt = ST_WALK;
               w_load      = 1'b1;
               w_load_val  = TW'(WALK_CYC - 1);
            end
         end
         ST_WALK: begin
            if (w_tc) begin
               w_state_nxt = ST_FLASH;
               w_load      = 1'b1;
               w_load_val  = TW'(CNT_CYC - 1);
               w_dig_nxt   = 4'(CNT_START);
            end
         end
         ST_FLASH: begin
            if (w_tc) begin
               w_load = 1'b1;
               if (r_dig == 4'd0) begin
                  w_state_nxt = ST_STOP;
                  w_load_val  = TW'(HAND_CYC - 1);
               end else begin
                  w_dig_nxt  = r_dig - 4'd1;
                  w_load_val = TW'(CNT_CYC - 1);
               end
            end
         end
         default: begin
            w_state_nxt = ST_STOP;
            w_load      = 1'b1;
            w_load_val  = TW'(HAND_CYC - 1);
         end
      endcase
   end

   // A fresh step shows the hand; otherwise the next count decides.
   always_comb begin
      w_walk_nxt   = (w_state_nxt == ST_WALK);
      w_num_on_nxt = (w_state_nxt == ST_FLASH);
      w_num_nxt    = (w_state_nxt == ST_FLASH) ? w_dig_nxt : 4'd0;
      w_hand_nxt   = 1'b0;
      if (w_state_nxt == ST_STOP)
         w_hand_nxt = 1'b1;
      else if (w_state_nxt == ST_FLASH)
         w_hand_nxt = w_load || (w_cnt > HAND_TH);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= ST_STOP;
         r_dig    <= 4'd0;
         r_walk   <= 1'b0;
         r_hand   <= 1'b1;
         r_num_on <= 1'b0;
         r_num    <= 4'd0;
      end else begin
         r_state  <= w_state_nxt;
         r_dig    <= w_dig_nxt;
         r_walk   <= w_walk_nxt;
         r_hand   <= w_hand_nxt;
         r_num_on <= w_num_on_nxt;
         r_num    <= w_num_nxt;
      end
   end

   assign walk   = r_walk;
   assign hand   = r_hand;
   assign num_on = r_num_on;
   assign num    = r_num;

endmodule

// File: tb/tb_cwalk.sv
// Bench for cwalk: default instance plus a CNT_START=0 / CNT_CYC=3 corner instance,
// checked cycle by cycle against a closed-form model through a scoreboard queue.
module tb_cwalk;

   logic       clk = 1'b0;
   logic       reset;
   logic       walk1, hand1, num_on1;
   logic [3:0] num1;
   logic       walk2, hand2, num_on2;
   logic [3:0] num2;

   int total = 0;
   int bad   = 0;

   logic [6:0] exp_q1[$];
   logic [6:0] exp_q2[$];

   localparam logic [6:0] RST_OUT = 7'b0100000;

   always #10 clk = ~clk;

   cwalk u_dut (
      .clk    (clk),
      .reset  (reset),
      .walk   (walk1),
      .hand   (hand1),
      .num_on (num_on1),
      .num    (num1)
   );

   cwalk #(
      .HAND_CYC  (2),
      .WALK_CYC  (1),
      .CNT_START (0),
      .CNT_CYC   (3)
   ) u_dut2 (
      .clk    (clk),
      .reset  (reset),
      .walk   (walk2),
      .hand   (hand2),
      .num_on (num_on2),
      .num    (num2)
   );

   task automatic chk(input string tag, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   // Expected {walk,hand,num_on,num} k edges after reset release.
   function automatic logic [6:0] model(input int k, input int h, input int w,
                                        input int s, input int c);
      int per, m, f, pos;
      logic [3:0] d;
      per = h + w + (s + 1) * c;
      m   = k % per;
      if (m < h) return 7'b0100000;
      if (m < h + w) return 7'b1000000;
      f   = m - h - w;
      pos = f % c;
      d   = 4'(s - f / c);
      return {1'b0, (pos < c / 2), 1'b1, d};
   endfunction

   task automatic push_exp(input int k);
      exp_q1.push_back(model(k, 20, 16, 9, 2));
      exp_q2.push_back(model(k, 2, 1, 0, 3));
   endtask

   task automatic pop_cmp(input int k);
      logic [6:0] e;
      e = exp_q1.pop_front();
      chk($sformatf("u1_k%0d", k), {walk1, hand1, num_on1, num1}, e);
      e = exp_q2.pop_front();
      chk($sformatf("u2_k%0d", k), {walk2, hand2, num_on2, num2}, e);
      chk($sformatf("excl_k%0d", k), int'(walk1 & hand1), 0);
   endtask

   // Call right after reset release; k=0 is the interval before the first edge.
   task automatic run_phase(input int ncyc, input string ph);
      int   rise[$];
      int   fall_k = -1;
      int   non = 0;
      logic pw;
      push_exp(0);
      #1;
      pop_cmp(0);
      pw = walk1;
      for (int k = 1; k <= ncyc; k++) begin
         push_exp(k);
         @(negedge clk);
         pop_cmp(k);
         if (walk1 && !pw) rise.push_back(k);
         if (!walk1 && pw && fall_k < 0) fall_k = k;
         if (num_on1 && k < 56) non++;
         pw = walk1;
      end
      chk({ph, "_stop_len"}, (rise.size() > 0) ? rise[0] : -1, 20);
      chk({ph, "_walk_len"}, (rise.size() > 0) ? fall_k - rise[0] : -1, 16);
      chk({ph, "_flash_len"}, non, 20);
      if (ncyc >= 120)
         chk({ph, "_period"}, (rise.size() > 1) ? rise[1] - rise[0] : -1, 56);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      reset = 1'b1;
      #50;
      chk("rst_init_u1", {walk1, hand1, num_on1, num1}, RST_OUT);
      chk("rst_init_u2", {walk2, hand2, num_on2, num2}, RST_OUT);
      #55 reset = 1'b0;
      run_phase(140, "p1");

      found = 1'b0;
      for (int i = 0; i < 80 && !found; i++) begin
         @(negedge clk);
         if (num_on1 && num1 == 4'd5) found = 1'b1;
      end
      chk("find_num5", int'(found), 1);

      reset = 1'b1;
      #1;
      chk("rst_async_u1", {walk1, hand1, num_on1, num1}, RST_OUT);
      chk("rst_async_u2", {walk2, hand2, num_on2, num2}, RST_OUT);
      @(negedge clk);
      chk("rst_hold_u1", {walk1, hand1, num_on1, num1}, RST_OUT);
      @(negedge clk);
      #5 reset = 1'b0;
      run_phase(60, "p2");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
